// File: rtl/booth8_seq_mul.sv
// Sequential signed radix-2 Booth multiplier that drives an external ripple add/sub stage.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand goes straight to DONE with a zero product.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on the accepting edge
// CALC   | one Booth add/sub/no-op plus arithmetic shift per clock
// DONE   | one-cycle done pulse, product valid
module booth8_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_s,
  input  logic [WIDTH-1:0]     add_out,
  input  logic                 add_c,
  input  logic                 add_v
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] t_val;
  logic             sgn;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             unused_add_c;

  assign unused_add_c = add_c;

  assign add_a = a_q;
  assign add_b = m_q;
  assign busy  = (state == S_CALC);
  assign done  = (state == S_DONE);

  // The stage result can overflow (e.g. 0 - (-128)); its true sign is out[msb] ^ v.
  always_comb begin
    add_s = 1'b0;
    t_val = a_q;
    sgn   = a_q[WIDTH-1];
    if (state == S_CALC) begin
      case ({q_q[0], q_m1})
        2'b01: begin
          t_val = add_out;
          sgn   = add_out[WIDTH-1] ^ add_v;
        end
        2'b10: begin
          add_s = 1'b1;
          t_val = add_out;
          sgn   = add_out[WIDTH-1] ^ add_v;
        end
        default: ;
      endcase
    end
  end

  assign a_nxt = {sgn, t_val[WIDTH-1:1]};
  assign q_nxt = {t_val[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m_q  <= mcand;
            q_q  <= mplier;
            a_q  <= '0;
            q_m1 <= 1'b0;
            cnt  <= '0;
`ifdef BOOTH_ZERO_SKIP_EN
            if ((mcand == '0) || (mplier == '0)) begin
              product <= '0;
              state   <= S_DONE;
            end else begin
              state <= S_CALC;
            end
`else
            state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          a_q  <= a_nxt;
          q_q  <= q_nxt;
          q_m1 <= q_q[0];
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            product <= {a_nxt, q_nxt};
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth8_seq_mul.sv
// Randomized self-checking bench for booth8_seq_mul, with a behavioural add/sub stage attached.
// Expected products come from plain signed integer multiplication.
module tb_booth8_seq_mul;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_s;
  logic [7:0]  add_out;
  logic        add_c;
  logic        add_v;

  int n_pass;
  int n_total;

  booth8_seq_mul #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .add_out(add_out), .add_c(add_c), .add_v(add_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ripple add/sub stage model
  logic [8:0] sum9;
  always_comb begin
    if (add_s) sum9 = {1'b0, add_a} + {1'b0, ~add_b} + 9'd1;
    else       sum9 = {1'b0, add_a} + {1'b0, add_b};
  end
  assign add_out = sum9[7:0];
  assign add_c   = sum9[8];
  assign add_v   = add_s ? ((add_a[7] != add_b[7]) && (add_out[7] != add_a[7]))
                         : ((add_a[7] == add_b[7]) && (add_out[7] != add_a[7]));

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int ia, ib, pr;
    ia = $signed(a);
    ib = $signed(b);
    pr = ia * ib;
    return pr[15:0];
  endfunction

  function automatic bit skips(input logic [7:0] a, input logic [7:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
    return (a == 8'd0) || (b == 8'd0);
`else
    return 1'b0;
`endif
  endfunction

  // lat counts negedges after the accepting edge until done is seen (0 = never)
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int busy_n, output int lat,
                        output bit sub_first, output bit saw_v);
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; lat = 0; sub_first = 1'b0; saw_v = 1'b0; p = 'x;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1 && busy) sub_first = add_s;
      if (busy) begin
        busy_n++;
        if (add_s && add_v) saw_v = 1'b1;
      end
      if (done) begin
        lat = k;
        p = product;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p; int bn, lat; bit sf, sv;
    int exp_lat, exp_bn;
    run_op(a, b, p, bn, lat, sf, sv);
    exp_lat = skips(a, b) ? 1 : 9;
    exp_bn  = skips(a, b) ? 0 : 8;
    n_total++;
    if (p !== ref_mul(a, b)) $display("FAIL %s product a=%h b=%h got %h want %h", name, a, b, p, ref_mul(a, b));
    else n_pass++;
    n_total++;
    if (lat != exp_lat) $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    else n_pass++;
    n_total++;
    if (bn != exp_bn) $display("FAIL %s busy_cycles got %0d want %0d", name, bn, exp_bn);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mcand = 8'h00; mplier = 8'h00;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, product, add_a, add_b, add_s} !== 35'd0)
      $display("FAIL reset_outputs got busy=%b done=%b product=%h add_a=%h add_b=%h add_s=%b want all 0",
               busy, done, product, add_a, add_b, add_s);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] p; int bn, lat; bit sf, sv;
    run_op(8'd3, 8'd5, p, bn, lat, sf, sv);
    n_total++;
    if (p !== 16'h000F) $display("FAIL basic_product got %h want 000f", p); else n_pass++;
    n_total++;
    if (bn != 8) $display("FAIL basic_busy_cycles got %0d want 8", bn); else n_pass++;
    n_total++;
    if (lat != 9) $display("FAIL basic_latency got %0d want 9", lat); else n_pass++;
    n_total++;
    if (sf !== 1'b1) $display("FAIL basic_sub_first got %b want 1", sf); else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL basic_done_one_cycle got %b want 0", done); else n_pass++;
    n_total++;
    if (product !== 16'h000F) $display("FAIL basic_product_held got %h want 000f", product); else n_pass++;
  endtask

  task automatic test_negative;
    check_op("neg_m3x5", 8'hFD, 8'd5);
    check_op("neg_5xm3", 8'd5, 8'hFD);
    check_op("neg_m7xm9", 8'hF9, 8'hF7);
  endtask

  task automatic test_overflow;
    logic [15:0] p; int bn, lat; bit sf, sv;
    run_op(8'h80, 8'h80, p, bn, lat, sf, sv);
    n_total++;
    if (p !== 16'h4000) $display("FAIL ovf_product got %h want 4000", p); else n_pass++;
    n_total++;
    if (sv !== 1'b1) $display("FAIL ovf_add_v_seen got %b want 1", sv); else n_pass++;
    check_op("ovf_m128x1", 8'h80, 8'h01);
    check_op("ovf_1xm128", 8'h01, 8'h80);
  endtask

  task automatic test_start_ignored;
    int lat;
    logic [7:0] na, nb;
    @(negedge clk);
    mcand = 8'h7F; mplier = 8'h80; start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      mcand = 8'($urandom); mplier = 8'($urandom);
      if (done) begin lat = k; break; end
    end
    n_total++;
    if (lat != 9) $display("FAIL hold_latency got %0d want 9", lat); else n_pass++;
    n_total++;
    if (product !== 16'hC080) $display("FAIL hold_product got %h want c080", product); else n_pass++;
    na = 8'($urandom_range(1, 255)); nb = 8'($urandom_range(1, 255));
    mcand = na; mplier = nb;
    @(negedge clk);
    n_total++;
    if ({busy, done} !== 2'b00) $display("FAIL start_in_done_ignored got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL start_in_idle_accepted got busy=%b want 1", busy); else n_pass++;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin lat = k; break; end
      @(negedge clk);
    end
    n_total++;
    if (lat == 0) $display("FAIL second_op_done got timeout want done");
    else n_pass++;
    n_total++;
    if (product !== ref_mul(na, nb)) $display("FAIL second_op_product got %h want %h", product, ref_mul(na, nb));
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit seen_done;
    @(negedge clk);
    mcand = 8'd6; mplier = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({busy, done, product, add_a, add_b, add_s} !== 35'd0)
      $display("FAIL midrst_outputs got busy=%b done=%b product=%h add_a=%h add_b=%h add_s=%b want all 0",
               busy, done, product, add_a, add_b, add_s);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    n_total++;
    if (seen_done !== 1'b0) $display("FAIL midrst_no_done got done pulse want none"); else n_pass++;
    check_op("midrst_rerun", 8'd6, 8'd7);
  endtask

  task automatic test_zero;
    check_op("zero_mcand", 8'h00, 8'h55);
    check_op("zero_mplier", 8'hA3, 8'h00);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) check_op("random", 8'($urandom), 8'($urandom));
  endtask

  task automatic test_back_to_back;
    check_op("b2b_first", 8'h7F, 8'h7F);
    check_op("b2b_second", 8'h80, 8'h7F);
    check_op("b2b_third", 8'hFF, 8'hFF);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_start_ignored();
    test_reset_mid();
    test_zero();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
